// File: rtl/wide_add_sequencer.sv
// WORDS x 16-bit add/subtract built by cycling one 16-bit hybrid adder over the
// operand slices, with valid/ready handshakes on both the operand and result sides.

// 4-bit carry-lookahead block.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c;
endmodule

// 16-bit hybrid adder: each nibble is precomputed for carry-in 0 and 1 by CLA
// blocks, and the rippling block carries only drive the select muxes.
module top (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] sum,
  output logic        co
);
  logic [3:0][3:0] s0, s1;
  logic [3:0]      c0, c1;
  logic [4:0]      c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_blk
    cla4 u_c0 (.a(a[4*i +: 4]), .b(b[4*i +: 4]), .ci(1'b0), .s(s0[i]), .co(c0[i]));
    cla4 u_c1 (.a(a[4*i +: 4]), .b(b[4*i +: 4]), .ci(1'b1), .s(s1[i]), .co(c1[i]));
    assign sum[4*i +: 4] = c[i] ? s1[i] : s0[i];
    assign c[i+1]        = c[i] ? c1[i] : c0[i];
  end

  assign co = c[4];
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                ci,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                co,
  output logic                busy
);
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nx;
  logic [WORDS-1:0][15:0] a_r, b_r, sum_r;
  logic                   carry_r;
  logic [IW-1:0]          idx;
  logic [15:0]            slice_s;
  logic                   slice_co;
  logic                   last;
  logic                   accept;

  assign last   = (idx == IW'(WORDS-1));
  assign accept = in_valid & in_ready;
  assign busy   = (state != IDLE);
  assign sum    = sum_r;

  top u_add (
    .a   (a_r[idx]),
    .b   (b_r[idx]),
    .ci  (carry_r),
    .sum (slice_s),
    .co  (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtract is a + ~b + 1; the +1 enters as the slice-0 carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      co      <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= op ? ~b : b;
      carry_r <= op ? 1'b1 : ci;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_r[idx] <= slice_s;
      carry_r    <= slice_co;
      if (last) co  <= slice_co;
      else      idx <= idx + 1'b1;
    end
  end
endmodule
